frame_assembler: RTL and testbench
==================================

Name: frame_assembler

Overview:
- Upstream feeder for the 5x5 perceptron classifier.
- Accepts a serial pixel stream, assembles WIDTH-bit frames in a fill buffer, then hands each complete frame to a separate active buffer.
- Holds the active frame stable and asserts the classifier enable for one full scan window.
- Captures the classifier result on its ready strobe and reports it with a one-cycle valid pulse.

Parameters:
- WIDTH, 25, pixels per frame; pixel k maps to frame bit k.
- SCAN_CYCLES, 26, cycles en_out stays high per frame (WIDTH+1 = one full classifier index sweep 0..WIDTH).
- CNT_W, 8, width of the frames_done counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pix_valid  in  1  pixel present on pix_data.
- pix_data  in  1  pixel value (1 = set).
- pix_sof  in  1  qualifies pix_valid; marks the first pixel of a frame.
- pix_ready  out  1  block can accept a pixel this cycle.
- frame_out  out  WIDTH  active frame to the classifier `in`.
- en_out  out  1  classifier enable.
- cls_out  in  2  classifier class (10 cross, 01 circle, 00 none).
- cls_ready  in  1  classifier ready strobe.
- result  out  2  last captured class.
- result_valid  out  1  one-cycle pulse, result updated.
- sof_err  out  1  one-cycle pulse, partial frame discarded.
- frames_done  out  CNT_W  completed scans, wraps.

Behaviour:
- Reset (async, immediate)
  - All outputs 0: frame_out, en_out, result, result_valid, sof_err, frames_done.
  - Fill count 0, fill_full 0, FSM IDLE.
  - pix_ready goes to 1 on the first clock edge after rst deasserts.
  - Reset mid-scan drops en_out at once. No result is reported for the aborted frame.
- Fill side
  - pix_ready = !fill_full.
  - A pixel is accepted when pix_valid && pix_ready. It is written to fill bit [fill_cnt], then fill_cnt increments.
  - The accept that writes bit WIDTH-1 sets fill_full=1 and fill_cnt=0 on the same edge.
- Resync
  - Accepted pixel with pix_sof=1 while fill_cnt!=0: discard the partial frame.
  - That pixel is written to bit 0 and fill_cnt becomes 1.
  - sof_err pulses for one cycle.
  - pix_sof with fill_cnt==0 is normal; no error.
- Missing sof
  - The first pixel after a completed frame starts a new frame whether or not pix_sof is set; no error.
- Scan FSM, IDLE
  - en_out=0.
  - If fill_full: on the next edge copy fill buffer to frame_out, clear fill_full, enter SCAN with scan_cnt=0, and set en_out=1.
  - Latency from the last pixel accepted to en_out=1 is 2 cycles when the FSM is idle.
- Scan FSM, SCAN
  - en_out=1 and frame_out is constant.
  - scan_cnt increments each cycle.
  - On the edge where scan_cnt==SCAN_CYCLES-1: go to IDLE, set en_out=0, and increment frames_done (wraps at 2^CNT_W).
  - IDLE lasts at least one cycle between scans.
- Double buffering
  - The fill side keeps accepting pixels during SCAN.
  - A frame that completes during SCAN waits with fill_full=1 and pix_ready=0 until the next IDLE transfer.
- Result capture
  - cls_ready && en_out at a clock edge: result <= cls_out and result_valid=1 for exactly that following cycle.
  - cls_ready while en_out=0 is ignored.
  - Multiple strobes within one scan each capture; the last one wins.
- Widths
  - fill_cnt and scan_cnt are $clog2(WIDTH+1) bits.
  - All comparisons are unsigned.

Test Plan:
- Reset, then stream 25 pixels with pixels 0,4,12,20,24=1, sof on the first.
  - en_out rises 2 cycles after the last accept and stays high exactly 26 cycles.
  - frame_out=0x1101011 throughout.
  - cls_ready pulse with cls_out=10 gives result=10, result_valid one cycle, frames_done=1.
- Stream frame B during frame A's scan.
  - pix_ready drops after B's 25th pixel.
  - en_out has exactly one low cycle between scans.
  - frame_out switches to B only at the second rise; frames_done=2.
- Assert sof on pixel 10 of a frame.
  - sof_err pulses once.
  - The subsequent 24 pixels complete a frame, and frame_out contains only the post-sof pixels.
- Drive cls_ready=1 with cls_out=01 while en_out=0.
  - result stays 00 and result_valid stays 0.
- Assert rst mid-scan at scan_cnt=10.
  - en_out and frame_out go to 0 immediately, with no result_valid.
  - After release, a fresh frame scans normally.
- Run 256 scans.
  - frames_done wraps to 0.

Source files
------------

// File: rtl/frame_assembler.sv
// Serial pixel to frame assembler feeding the 5x5 perceptron classifier.
// Double-buffered: a fill buffer collects pixels while the active frame is scanned.
module frame_assembler #(
    parameter int WIDTH       = 25,
    parameter int SCAN_CYCLES = 26,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    input  logic             pix_data,
    input  logic             pix_sof,
    output logic             pix_ready,
    output logic [WIDTH-1:0] frame_out,
    output logic             en_out,
    input  logic [1:0]       cls_out,
    input  logic             cls_ready,
    output logic [1:0]       result,
    output logic             result_valid,
    output logic             sof_err,
    output logic [CNT_W-1:0] frames_done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    fill_cnt;
    logic [CW-1:0]    scan_cnt;
    logic [WIDTH-1:0] fill_buf;
    logic             fill_full;
    logic             rdy_en;
    logic             accept;
    logic             resync;
    logic             last_pix;
    logic             load;
    logic             scan_end;

    // Keeps pix_ready low until the first edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_en <= 1'b0;
        else     rdy_en <= 1'b1;
    end

    assign pix_ready = rdy_en & ~fill_full;
    assign accept    = pix_valid & pix_ready;
    assign resync    = accept & pix_sof & (fill_cnt != '0);
    assign last_pix  = (fill_cnt == CW'(WIDTH - 1));
    assign load      = (state == IDLE) & fill_full;
    assign scan_end  = (scan_cnt == CW'(SCAN_CYCLES - 1));

    // load and accept never coincide: load needs fill_full, accept needs !fill_full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_buf  <= '0;
            fill_cnt  <= '0;
            fill_full <= 1'b0;
            sof_err   <= 1'b0;
        end else begin
            sof_err <= resync;
            if (load) fill_full <= 1'b0;
            if (accept) begin
                if (resync) begin
                    fill_buf <= {{(WIDTH-1){1'b0}}, pix_data};
                    fill_cnt <= CW'(1);
                end else begin
                    fill_buf[fill_cnt] <= pix_data;
                    if (last_pix) begin
                        fill_full <= 1'b1;
                        fill_cnt  <= '0;
                    end else begin
                        fill_cnt <= fill_cnt + CW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            scan_cnt    <= '0;
            en_out      <= 1'b0;
            frame_out   <= '0;
            frames_done <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fill_full) begin
                        frame_out <= fill_buf;
                        scan_cnt  <= '0;
                        en_out    <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_end) begin
                        state       <= IDLE;
                        en_out      <= 1'b0;
                        frames_done <= frames_done + CNT_W'(1);
                    end else begin
                        scan_cnt <= scan_cnt + CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    en_out <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result       <= 2'b00;
            result_valid <= 1'b0;
        end else begin
            result_valid <= cls_ready & en_out;
            if (cls_ready && en_out) result <= cls_out;
        end
    end

endmodule

// File: tb/tb_frame_assembler.sv
// Directed bench for frame_assembler: fill, scan timing, resync,
// result capture, reset mid-scan and frames_done wrap.
module tb_frame_assembler;

    localparam int WIDTH = 25;
    localparam int CNT_W = 8;

    localparam logic [24:0] FR_A = 25'h1101011;
    localparam logic [24:0] FR_B = 25'h1555555;
    localparam logic [24:0] FR_D = 25'h1234567;
    localparam logic [24:0] FR_E = 25'h0ABCDEF;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             pix_valid = 1'b0;
    logic             pix_data = 1'b0;
    logic             pix_sof = 1'b0;
    logic             pix_ready;
    logic [WIDTH-1:0] frame_out;
    logic             en_out;
    logic [1:0]       cls_out = 2'b00;
    logic             cls_ready = 1'b0;
    logic [1:0]       result;
    logic             result_valid;
    logic             sof_err;
    logic [CNT_W-1:0] frames_done;

    int checks = 0;
    int errors = 0;

    int hi_run = 0;
    int lo_run = 0;
    int last_hi = 0;
    int last_lo = 0;
    int glitch = 0;
    int sof_cnt = 0;
    int rv_cnt = 0;
    logic [WIDTH-1:0] cur_frame = '0;

    frame_assembler #(.WIDTH(25), .SCAN_CYCLES(26), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .pix_valid(pix_valid),
        .pix_data(pix_data),
        .pix_sof(pix_sof),
        .pix_ready(pix_ready),
        .frame_out(frame_out),
        .en_out(en_out),
        .cls_out(cls_out),
        .cls_ready(cls_ready),
        .result(result),
        .result_valid(result_valid),
        .sof_err(sof_err),
        .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    // Run-length monitor of en_out, frame stability and pulse counts.
    always @(negedge clk) begin
        if (rst) begin
            hi_run = 0;
            lo_run = 0;
        end else begin
            if (en_out) begin
                if (hi_run == 0) begin
                    last_lo   = lo_run;
                    cur_frame = frame_out;
                end else if (frame_out !== cur_frame) begin
                    glitch++;
                end
                hi_run++;
                lo_run = 0;
            end else begin
                if (hi_run != 0) last_hi = hi_run;
                hi_run = 0;
                lo_run++;
            end
            if (sof_err) sof_cnt++;
            if (result_valid) rv_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [24:0] bits, input int n,
                             input bit sof_first);
        int g;
        for (int i = 0; i < n; i++) begin
            g = 0;
            while (!pix_ready && g < 200) begin
                step();
                g++;
            end
            if (!pix_ready) check("ready_timeout", 32'(pix_ready), 32'd1);
            pix_valid = 1'b1;
            pix_data  = bits[i];
            pix_sof   = sof_first && (i == 0);
            step();
        end
        pix_valid = 1'b0;
        pix_data  = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic wait_low();
        int n;
        n = 0;
        while (en_out && n < 100) begin
            step();
            n++;
        end
        check("en_fall", 32'(en_out), 32'd0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_frame", 32'(frame_out), 32'd0);
        check("rst_en", 32'(en_out), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_rv", 32'(result_valid), 32'd0);
        check("rst_sof_err", 32'(sof_err), 32'd0);
        check("rst_done", 32'(frames_done), 32'd0);
        repeat (2) step();
        rst = 1'b0;
        check("ready_pre", 32'(pix_ready), 32'd0);
        step();
        check("ready_post", 32'(pix_ready), 32'd1);

        // cls_ready while idle is ignored
        cls_ready = 1'b1;
        cls_out   = 2'b01;
        repeat (4) step();
        check("idle_cls_res", 32'(result), 32'd0);
        check("idle_cls_rv", 32'(rv_cnt), 32'd0);
        cls_ready = 1'b0;
        cls_out   = 2'b00;

        // frame A, then B streamed during A's scan
        send_bits(FR_A, 25, 1'b1);
        check("lat_en0", 32'(en_out), 32'd0);
        step();
        check("lat_en1", 32'(en_out), 32'd1);
        check("frame_a", 32'(frame_out), 32'(FR_A));
        fork
            begin
                send_bits(FR_B, 25, 1'b0);
                check("b_ready_drop", 32'(pix_ready), 32'd0);
                check("b_still_scan", 32'(en_out), 32'd1);
            end
            begin
                repeat (5) step();
                cls_ready = 1'b1;
                cls_out   = 2'b10;
                step();
                check("cls_res", 32'(result), 32'd2);
                check("cls_rv", 32'(result_valid), 32'd1);
                cls_ready = 1'b0;
                cls_out   = 2'b00;
                step();
                check("cls_rv_end", 32'(result_valid), 32'd0);
                check("cls_rv_cnt", 32'(rv_cnt), 32'd1);
            end
        join
        wait_low();
        check("scan_a_len", 32'(last_hi), 32'd26);
        check("done_1", 32'(frames_done), 32'd1);
        check("a_held_low", 32'(frame_out), 32'(FR_A));
        step();
        check("b_rise", 32'(en_out), 32'd1);
        check("gap_len", 32'(last_lo), 32'd1);
        check("frame_b", 32'(frame_out), 32'(FR_B));
        wait_low();
        check("scan_b_len", 32'(last_hi), 32'd26);
        check("done_2", 32'(frames_done), 32'd2);
        check("no_sof_err", 32'(sof_cnt), 32'd0);

        // resync on pixel 10
        send_bits(25'h00003FF, 10, 1'b1);
        send_bits(FR_D, 25, 1'b1);
        step();
        check("d_rise", 32'(en_out), 32'd1);
        check("frame_d", 32'(frame_out), 32'(FR_D));
        check("sof_err_cnt", 32'(sof_cnt), 32'd1);
        wait_low();
        check("done_3", 32'(frames_done), 32'd3);

        // reset at scan_cnt 10
        send_bits(FR_E, 25, 1'b1);
        step();
        check("e_rise", 32'(en_out), 32'd1);
        repeat (10) step();
        rst = 1'b1;
        #1;
        check("mid_rst_en", 32'(en_out), 32'd0);
        check("mid_rst_frame", 32'(frame_out), 32'd0);
        check("mid_rst_rv", 32'(result_valid), 32'd0);
        check("mid_rst_done", 32'(frames_done), 32'd0);
        repeat (2) step();
        rst = 1'b0;
        step();
        check("post_rst_rv", 32'(rv_cnt), 32'd1);
        send_bits(FR_A, 25, 1'b1);
        step();
        check("fresh_rise", 32'(en_out), 32'd1);
        check("fresh_frame", 32'(frame_out), 32'(FR_A));
        wait_low();
        check("fresh_len", 32'(last_hi), 32'd26);
        check("fresh_done", 32'(frames_done), 32'd1);

        // 255 more scans wrap frames_done to 0
        for (int k = 0; k < 255; k++) begin
            send_bits(25'(k * 32'h0013579), 25, 1'b0);
        end
        repeat (80) step();
        check("wrap_done", 32'(frames_done), 32'd0);
        check("wrap_en", 32'(en_out), 32'd0);
        check("wrap_len", 32'(last_hi), 32'd26);
        check("glitch", 32'(glitch), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
